uart_tx_block: RTL

UART-style transmitter: accepts a parallel word through a valid/ready handshake and serializes it as one frame: start bit, data bits LSB first, stop bit. Each bit is held for a fixed number of clocks. It is the transmit-side counterpart of the serial-to-parallel receive path and drives the same idle-high line format: inactive value 1, start 0, stop 1. It sits between the packet/control logic and the serial output pad.

---
 rtl/uart_tx_block.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_block.sv
// UART-style serial transmitter: accepts one word per valid/ready handshake and
// sends it as start bit, NUM_BITS data bits LSB first, stop bit on an idle-high line.
module uart_tx_block #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_BITS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    logic [1:0]          state_r;
    logic [NUM_BITS-1:0] shift_r;
    logic [CW-1:0]       clk_cnt_r;
    logic [BW-1:0]       bit_cnt_r;
    logic                serial_out_r;
    logic                tx_busy_r;
    logic                tx_done_r;

    logic [1:0]          state_s;
    logic [NUM_BITS-1:0] shift_s;
    logic [CW-1:0]       clk_cnt_s;
    logic [BW-1:0]       bit_cnt_s;
    logic                done_s;
    logic                serial_s;
    logic                bit_end_s;
    logic                tx_ready_s;
    logic [NUM_BITS:0]   shift_fill_s;

    assign tx_ready_s = (state_r == IDLE) && n_rst;
    assign tx_ready   = tx_ready_s;
    assign serial_out = serial_out_r;
    assign tx_busy    = tx_busy_r;
    assign tx_done    = tx_done_r;

    // Next-state, counter and shift-register update for the frame sequencer
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        clk_cnt_s    = clk_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        done_s       = 1'b0;
        bit_end_s    = (clk_cnt_r == CLK_LAST);
        shift_fill_s = {1'b1, shift_r};
        case (state_r)
            IDLE: begin
                if (tx_ready_s && tx_valid) begin
                    state_s   = START;
                    shift_s   = tx_data;
                    clk_cnt_s = {CW{1'b0}};
                    bit_cnt_s = {BW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s   = DATA;
                    clk_cnt_s = {CW{1'b0}};
                end else begin
                    clk_cnt_s = clk_cnt_r + CLK_ONE;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    clk_cnt_s = {CW{1'b0}};
                    shift_s   = shift_fill_s[NUM_BITS:1];
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CLK_ONE;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_s   = IDLE;
                    clk_cnt_s = {CW{1'b0}};
                    done_s    = 1'b1;
                end else begin
                    clk_cnt_s = clk_cnt_r + CLK_ONE;
                end
            end
            default: begin
                state_s   = IDLE;
                shift_s   = {NUM_BITS{1'b1}};
                clk_cnt_s = {CW{1'b0}};
                bit_cnt_s = {BW{1'b0}};
            end
        endcase
    end

    // Line level is derived from the next state so the registered pin lines up with the state
    always_comb begin
        serial_s = 1'b1;
        case (state_s)
            START:   serial_s = 1'b0;
            DATA:    serial_s = shift_s[0];
            default: serial_s = 1'b1;
        endcase
    end

    // State and registered outputs; reset aborts any frame and returns the line high
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r      <= IDLE;
            shift_r      <= {NUM_BITS{1'b1}};
            clk_cnt_r    <= {CW{1'b0}};
            bit_cnt_r    <= {BW{1'b0}};
            serial_out_r <= 1'b1;
            tx_busy_r    <= 1'b0;
            tx_done_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            clk_cnt_r    <= clk_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            serial_out_r <= serial_s;
            tx_busy_r    <= (state_s != IDLE);
            tx_done_r    <= done_s;
        end
    end

endmodule
